rtc_multi_capture: RTL
======================

// Module: rtc_multi_capture
// PURPOSE
//  Next-generation real-time clock. Free-running CNT_W-bit timestamp counter; NUM_CH event inputs, each
//  synchronised and timestamped on its rising edge into a shared FIFO; compare-scheduled piezo pulse of
//  programmable length. CPU access over the Avalon-MM slave from the HPS lightweight bridge.
// PARAMETERS
//  NUM_CH      4    event channels (1..32)
//  FIFO_DEPTH  16   capture FIFO entries (power of 2, 2..256)
//  CNT_W       32   timestamp width (<=32; readdata zero-extended)
//  PULSE_W     16   pulse-length counter width
// PORTS
//  clock                   in   1        system clock (50 MHz)
//  reset                   in   1        synchronous, active-high reset
//  event_in                in   NUM_CH   asynchronous event inputs
//  avalon_slave_address    in   16       [15:8] register select, [7:0] ignored
//  avalon_slave_write      in   1        write strobe
//  avalon_slave_writedata  in   32       write data
//  avalon_slave_read       in   1        read strobe
//  avalon_slave_readdata   out  32       read data
//  avalon_slave_waitrequest out 1        read stall
//  piezo_enable            out  1        registered ultrasound pulse output
// BEHAVIOUR
//  Reset (sync): time_cnt, en_mask, FIFO, overrun, pending, pulse length, readdata = 0; waitrequest = 0;
//   piezo_enable = 0; FSM = IDLE. Asserting reset mid-pulse drops piezo_enable on the next edge.
//  Counter: +1 per clock, wraps 2^CNT_W-1 -> 0. A write to 0x00 loads writedata next cycle; increment resumes after.
//  Events: 2-flop synchroniser, then rising-edge detect. Edge on an enabled channel latches time_cnt (value in the
//   detect cycle) into a per-channel pending register. Edge while that channel is still pending: edge dropped,
//   overrun[ch] set (sticky). Arbiter pushes one pending entry per cycle, lowest channel index first.
//   Entry = {ch[7:0], ts}. FIFO full: pending entries hold, no loss. Push and pop in the same cycle are legal when full.
//  Registers (addr[15:8]):
//   0x00 R/W time_cnt.  0x01 R/W en_mask[NUM_CH-1:0].  0x02 R head timestamp, no side effect (0 if empty).
//   0x03 R {empty[31], 7'b0, level[23:16], 8'b0, head_ch[7:0]}; pops the head if non-empty.
//   0x04 R overrun mask; W write-1-to-clear.  0x05 R/W pulse length (PULSE_W bits).
//   0x06 W fire immediately.  0x07 W arm at time writedata; R last pulse start timestamp.
//   Other addresses: read 0xDEADBEEF; writes ignored.
//  Avalon read: waitrequest = read & ~rd_done, where rd_done is a 1-cycle registered flag. readdata is registered
//   and valid in the cycle waitrequest is low. Exactly one pop per read transaction. Writes never stall.
//  Pulse FSM:
//   IDLE  -> PULSE on write 0x06; -> ARMED on write 0x07 (target latched).
//   ARMED -> PULSE when time_cnt == target. Write 0x06 fires now; write 0x07 re-targets.
//   PULSE: piezo_enable = 1 for exactly len cycles, starting the cycle after entry. start_ts = time_cnt at entry.
//    -> IDLE when count expires. Writes 0x06/0x07 are ignored in PULSE.
//   len == 0: fire/arm writes are ignored and the FSM stays IDLE. A time_cnt load may skip the target;
//    ARMED then waits for the next wrap.
// TESTING
//  1 Reset, then idle 10 cycles -> read 0x00 returns 10..12 (±read latency); waitrequest high exactly 1 cycle.
//  2 en_mask=0xF; pulse ch0 and ch2 in the same cycle -> two entries, ch0 first; timestamps equal; level=2.
//  3 Fill FIFO (16), then 3 more edges on ch1 -> entries held; 2nd/3rd edge set overrun[1]; pop frees a slot;
//    next entry enters.
//  4 len=5, write 0x07 with time_cnt+20 -> piezo_enable high cycles +21..+25; 0x07 read = target.
//  5 Write 0x00 = 0xFFFFFFFE -> wraps to 0 after 2 cycles; armed target 0x1 fires after the wrap.
//  6 Assert reset mid-pulse with FIFO non-empty -> piezo_enable=0 next cycle; 0x03 reads empty=1.

Source files
------------

// File: rtl/rtc_multi_capture.sv
// Real-time clock with a free-running timestamp counter, multi-channel event capture into a
// shared FIFO, and a compare-scheduled piezo pulse. Avalon-MM slave register interface.
module rtc_multi_capture #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PULSE_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] event_in,
  input  logic [15:0]       avalon_slave_address,
  input  logic              avalon_slave_write,
  input  logic [31:0]       avalon_slave_writedata,
  input  logic              avalon_slave_read,
  output logic [31:0]       avalon_slave_readdata,
  output logic              avalon_slave_waitrequest,
  output logic              piezo_enable
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW = 8 + CNT_W;

  typedef enum logic [1:0] {StIdle, StArmed, StPulse} state_e;

  logic [7:0] reg_sel;
  logic       unused_addr;
  assign reg_sel     = avalon_slave_address[15:8];
  assign unused_addr = ^avalon_slave_address[7:0];

  logic rd_done_q;
  logic rd_start;
  assign rd_start = avalon_slave_read & ~rd_done_q;
  assign avalon_slave_waitrequest = avalon_slave_read & ~rd_done_q;

  logic wr_time, wr_mask, wr_ovr, wr_len, wr_fire, wr_arm;
  assign wr_time = avalon_slave_write && (reg_sel == 8'h00);
  assign wr_mask = avalon_slave_write && (reg_sel == 8'h01);
  assign wr_ovr  = avalon_slave_write && (reg_sel == 8'h04);
  assign wr_len  = avalon_slave_write && (reg_sel == 8'h05);
  assign wr_fire = avalon_slave_write && (reg_sel == 8'h06);
  assign wr_arm  = avalon_slave_write && (reg_sel == 8'h07);

  logic [CNT_W-1:0]  time_cnt_q;
  logic [NUM_CH-1:0] en_mask_q;
  logic [NUM_CH-1:0] overrun_q;
  logic [PULSE_W-1:0] pulse_len_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      time_cnt_q  <= '0;
      en_mask_q   <= '0;
      pulse_len_q <= '0;
    end else begin
      time_cnt_q <= wr_time ? avalon_slave_writedata[CNT_W-1:0] : time_cnt_q + CNT_W'(1);
      if (wr_mask) en_mask_q <= avalon_slave_writedata[NUM_CH-1:0];
      if (wr_len)  pulse_len_q <= avalon_slave_writedata[PULSE_W-1:0];
    end
  end

  // Event synchroniser and rising-edge detect
  logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_CH-1:0] rise;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= event_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end
  assign rise = sync2_q & ~sync3_q & en_mask_q;

  // Per-channel pending slots and lowest-index-first arbitration into the FIFO
  logic [NUM_CH-1:0] pend_q;
  logic [CNT_W-1:0]  pend_ts_q [NUM_CH];
  logic [NUM_CH-1:0] sel_oh, granted, pend_free, latch, ovr_set;
  logic              found, push, pop, full, empty;
  logic [7:0]        grant_ch;
  logic [CNT_W-1:0]  grant_ts;

  always_comb begin
    found    = 1'b0;
    sel_oh   = '0;
    grant_ch = '0;
    grant_ts = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pend_q[i] && !found) begin
        found     = 1'b1;
        sel_oh[i] = 1'b1;
        grant_ch  = 8'(i);
        grant_ts  = pend_ts_q[i];
      end
    end
  end

  assign push      = found && (!full || pop);
  assign granted   = push ? sel_oh : '0;
  // A slot being drained this cycle can accept a new edge without overrun
  assign pend_free = ~pend_q | granted;
  assign latch     = rise & pend_free;
  assign ovr_set   = rise & ~pend_free;

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q    <= '0;
      overrun_q <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) pend_ts_q[i] <= '0;
    end else begin
      pend_q    <= (pend_q & ~granted) | latch;
      overrun_q <= (overrun_q & ~(wr_ovr ? avalon_slave_writedata[NUM_CH-1:0] : '0)) | ovr_set;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (latch[i]) pend_ts_q[i] <= time_cnt_q;
      end
    end
  end

  // Capture FIFO
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [EW-1:0] head;
  logic [CNT_W-1:0] head_ts;
  logic [7:0]    head_ch;

  assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = rd_start && (reg_sel == 8'h03) && !empty;
  assign head    = fifo_mem[rd_ptr_q];
  assign head_ts = empty ? '0 : head[CNT_W-1:0];
  assign head_ch = empty ? '0 : head[EW-1:CNT_W];

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= {grant_ch, grant_ts};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (!push && pop) count_q <= count_q - (AW + 1)'(1);
    end
  end

  // Pulse scheduler
  state_e             state_q;
  logic [CNT_W-1:0]   target_q, start_ts_q;
  logic [PULSE_W-1:0] pulse_cnt_q;
  logic               len_ok;
  assign len_ok = (pulse_len_q != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      piezo_enable <= 1'b0;
      pulse_cnt_q  <= '0;
      target_q     <= '0;
      start_ts_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StArmed: begin
          if (wr_fire && len_ok) begin
            state_q      <= StPulse;
            piezo_enable <= 1'b1;
            pulse_cnt_q  <= pulse_len_q;
            start_ts_q   <= time_cnt_q;
          end else if (wr_arm && len_ok) begin
            state_q  <= StArmed;
            target_q <= avalon_slave_writedata[CNT_W-1:0];
          end else if (state_q == StArmed && time_cnt_q == target_q) begin
            if (len_ok) begin
              state_q      <= StPulse;
              piezo_enable <= 1'b1;
              pulse_cnt_q  <= pulse_len_q;
              start_ts_q   <= time_cnt_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StPulse: begin
          if (pulse_cnt_q <= PULSE_W'(1)) begin
            state_q      <= StIdle;
            piezo_enable <= 1'b0;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - PULSE_W'(1);
          end
        end
        default: begin
          state_q      <= StIdle;
          piezo_enable <= 1'b0;
        end
      endcase
    end
  end

  // Register read path
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = 32'hDEAD_BEEF;
    case (reg_sel)
      8'h00: rd_mux = 32'(time_cnt_q);
      8'h01: rd_mux = 32'(en_mask_q);
      8'h02: rd_mux = 32'(head_ts);
      8'h03: rd_mux = {empty, 7'b0, 8'(count_q), 8'b0, head_ch};
      8'h04: rd_mux = 32'(overrun_q);
      8'h05: rd_mux = 32'(pulse_len_q);
      8'h06: rd_mux = 32'h0;
      8'h07: rd_mux = 32'(start_ts_q);
      default: rd_mux = 32'hDEAD_BEEF;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_done_q             <= 1'b0;
      avalon_slave_readdata <= '0;
    end else begin
      rd_done_q <= rd_start;
      if (rd_start) avalon_slave_readdata <= rd_mux;
    end
  end

endmodule
